mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Pipeline MEM stage; produces the writeback bundle (isJumpAndLink, pc_4,
//  shouldWriteMemoryElseAluOutputToRegister, memoryData, aluOutput) that the
//  WB mux consumes.
//  - Accepts one instruction per cycle from EX.
//  - Issues loads/stores to data memory over a req/ready bus.
//  - Aligns and extends load data, then registers everything for WB.
//  - Stalls upstream while a memory access is outstanding.
// PARAMETERS
//  ADDR_W  32  data-bus address width
//  RESET_PC  32'h0  reset value of wbPc4
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   asynchronous reset, active-high
//  exValid     in   1   EX bundle valid this cycle
//  exIsLoad    in   1   load instruction
//  exIsStore   in   1   store instruction
//  exSize      in   2   00 byte, 01 half, 10 word (11 treated as word)
//  exSignExt   in   1   sign-extend load data (byte/half)
//  exAluOut    in   32  ALU result / effective address
//  exStoreData in   32  rt value for stores
//  exIsJal     in   1   jal/jalr marker, passed through
//  exPc4       in   32  PC+4, passed through
//  exRegWrite  in   1   instruction writes a register
//  exDestReg   in   5   destination register number
//  stallOut    out  1   hold EX; high for every cycle in BUSY
//  memReq      out  1   bus request
//  memWe       out  1   1 = store
//  memAddr     out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//  memWdata    out  32  store data replicated into lanes
//  memBe       out  4   byte enables, little-endian
//  memReady    in   1   bus completes request this cycle
//  memRdata    in   32  read data, valid when memReady=1 on a load
//  wbValid, wbIsJal, wbM2reg, wbRegWrite  out 1; wbDestReg out 5;
//  wbPc4, wbMemData, wbAluOut  out 32   registered WB bundle
// BEHAVIOUR
//  - Reset: state IDLE; memReq/memWe/stallOut/wbValid/wbRegWrite/wbIsJal/wbM2reg=0;
//    memBe/memAddr/memWdata/wbMemData/wbAluOut/wbDestReg=0; wbPc4=RESET_PC.
//    Async: memReq drops immediately, even mid-access. A pending access is abandoned.
//  - IDLE, exValid & ~(load|store): WB regs load EX bundle at next edge.
//    wbMemData=0, wbM2reg=0; latency 1.
//  - IDLE, exValid & (load|store):
//    - Latch addr/size/signExt/storeData/dest/pc4/jal.
//    - Next edge -> BUSY.
//    - wbValid=0 that edge (bubble).
//  - IDLE, ~exValid: wbValid=0 at next edge.
//  - BUSY: memReq=1; memWe/memAddr/memBe/memWdata held stable until memReady.
//    stallOut=1; EX inputs ignored.
//  - BUSY & memReady: at edge -> IDLE.
//    - WB bundle written: wbValid=1.
//    - wbM2reg=load.
//    - wbRegWrite=load & latched regWrite.
//    - wbMemData=extracted load data (0 for store).
//  - BUSY & ~memReady: stay BUSY; no timeout.
//  - Min mem-op latency: accept edge + 1 ready cycle = 2 cycles to wbValid.
//  - memBe by size, a=addr[1:0]:
//    - byte: 1<<a
//    - half: 4'b0011<<{a[1],1'b0}
//    - word: 4'b1111
//  - memWdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  - Load extract: byte lane a, half lane a[1]; sign/zero-extend per exSignExt.
//  - memReady while IDLE is ignored.
// CONFIGURATION
//  - MEM_MISALIGN_TRAP_EN defined: adds output misalignTrap (1 bit, reset 0).
//    - Half with a[0]=1, or word with a!=0: no bus access; stays IDLE.
//    - Next edge: wbValid=1, wbRegWrite=0, misalignTrap=1 for exactly one cycle.
//  - MEM_MISALIGN_TRAP_EN undefined: no port.
//    - Half ignores a[0]; word ignores a[1:0]; access proceeds normally.
// TESTING
//  1. ALU op exValid=1, exAluOut=32'h1234, exRegWrite=1, dest=5
//     -> next cycle wbValid=1, wbAluOut=32'h1234, wbM2reg=0, stallOut never high.
//  2. lb addr=32'h103, signExt=1; memReady 3 cycles after BUSY, memRdata=32'h80FF_FFFF
//     -> memBe=4'b1000, stallOut high 3 cycles, wbMemData=32'hFFFF_FF80, wbM2reg=1.
//  3. sh addr=32'h202, data=32'hABCD
//     -> memBe=4'b1100, memWdata=32'hABCD_ABCD, memWe=1, wbRegWrite=0.
//  4. jal exIsJal=1, exPc4=32'h40
//     -> wbIsJal=1, wbPc4=32'h40 one cycle later.
//  5. Load in BUSY, rst pulsed before memReady
//     -> memReq=0 and wbValid=0 same cycle; next op after rst completes normally.
//  6. [MEM_MISALIGN_TRAP_EN] lw addr=32'h101
//     -> memReq stays 0; misalignTrap=1 one cycle; wbRegWrite=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ready bus, aligns load data, registers the WB bundle.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds misalignTrap; misaligned half/word ops trap instead of accessing).
module mem_access_stage #(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exValid,
  input  logic              exIsLoad,
  input  logic              exIsStore,
  input  logic [1:0]        exSize,
  input  logic              exSignExt,
  input  logic [31:0]       exAluOut,
  input  logic [31:0]       exStoreData,
  input  logic              exIsJal,
  input  logic [31:0]       exPc4,
  input  logic              exRegWrite,
  input  logic [4:0]        exDestReg,
  output logic              stallOut,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWdata,
  output logic [3:0]        memBe,
  input  logic              memReady,
  input  logic [31:0]       memRdata,
  output logic              wbValid,
  output logic              wbIsJal,
  output logic              wbM2reg,
  output logic              wbRegWrite,
  output logic [4:0]        wbDestReg,
  output logic [31:0]       wbPc4,
  output logic [31:0]       wbMemData,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalignTrap,
`endif
  output logic [31:0]       wbAluOut
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned BE_W   = 4;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, stateNext;

  logic isMemOp_c, misaligned_c;
  logic acceptMem_c, acceptPass_c, acceptTrap_c, complete_c, bubble_c;
  logic [BE_W-1:0]   beNext_c;
  logic [DATA_W-1:0] wdataNext_c, loadData_c;
  logic [7:0]        loadByte_c;
  logic [15:0]       loadHalf_c;

  // Operation latched at accept time for use when the bus completes
  logic [DATA_W-1:0] latAlu, latPc4;
  logic [REG_W-1:0]  latDest;
  logic [1:0]        latSize;
  logic              latJal, latRegWrite, latIsLoad, latSignExt;

  assign isMemOp_c = exIsLoad | exIsStore;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned_c = ((exSize == 2'b01) & exAluOut[0]) |
                        (exSize[1] & (exAluOut[1:0] != 2'b00));
`else
  assign misaligned_c = 1'b0;
`endif

  // Byte enables and lane-replicated store data for the accepted op
  always_comb begin
    beNext_c    = 4'b1111;
    wdataNext_c = exStoreData;
    case (exSize)
      2'b00: begin
        beNext_c    = 4'b0001 << exAluOut[1:0];
        wdataNext_c = {4{exStoreData[7:0]}};
      end
      2'b01: begin
        beNext_c    = 4'b0011 << {exAluOut[1], 1'b0};
        wdataNext_c = {2{exStoreData[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and extension of returning load data
  always_comb begin
    loadByte_c = memRdata[{latAlu[1:0], 3'b000} +: 8];
    loadHalf_c = memRdata[{latAlu[1], 4'b0000} +: 16];
    loadData_c = memRdata;
    case (latSize)
      2'b00:   loadData_c = latSignExt ? {{24{loadByte_c[7]}}, loadByte_c} : {24'b0, loadByte_c};
      2'b01:   loadData_c = latSignExt ? {{16{loadHalf_c[15]}}, loadHalf_c} : {16'b0, loadHalf_c};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (acceptMem_c) stateNext = BUSY;
      BUSY:    if (memReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    acceptMem_c  = 1'b0;
    acceptPass_c = 1'b0;
    acceptTrap_c = 1'b0;
    complete_c   = 1'b0;
    bubble_c     = 1'b0;
    case (state)
      IDLE: begin
        if (exValid & isMemOp_c & misaligned_c) acceptTrap_c = 1'b1;
        else if (exValid & isMemOp_c)           acceptMem_c  = 1'b1;
        else if (exValid)                       acceptPass_c = 1'b1;
        else                                    bubble_c     = 1'b1;
      end
      BUSY:    complete_c = memReady;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallOut    <= 1'b0;
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWdata    <= '0;
      memBe       <= '0;
      wbValid     <= 1'b0;
      wbIsJal     <= 1'b0;
      wbM2reg     <= 1'b0;
      wbRegWrite  <= 1'b0;
      wbDestReg   <= '0;
      wbPc4       <= RESET_PC;
      wbMemData   <= '0;
      wbAluOut    <= '0;
      latAlu      <= '0;
      latPc4      <= '0;
      latDest     <= '0;
      latSize     <= '0;
      latJal      <= 1'b0;
      latRegWrite <= 1'b0;
      latIsLoad   <= 1'b0;
      latSignExt  <= 1'b0;
    end else if (acceptMem_c) begin
      latAlu      <= exAluOut;
      latPc4      <= exPc4;
      latDest     <= exDestReg;
      latSize     <= exSize;
      latJal      <= exIsJal;
      latRegWrite <= exRegWrite;
      latIsLoad   <= exIsLoad;
      latSignExt  <= exSignExt;
      stallOut    <= 1'b1;
      memReq      <= 1'b1;
      memWe       <= exIsStore & ~exIsLoad;
      memAddr     <= {exAluOut[ADDR_W-1:2], 2'b00};
      memBe       <= beNext_c;
      memWdata    <= wdataNext_c;
      wbValid     <= 1'b0;
      wbRegWrite  <= 1'b0;
    end else if (complete_c) begin
      stallOut    <= 1'b0;
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      wbValid     <= 1'b1;
      wbIsJal     <= latJal;
      wbM2reg     <= latIsLoad;
      wbRegWrite  <= latIsLoad & latRegWrite;
      wbDestReg   <= latDest;
      wbPc4       <= latPc4;
      wbMemData   <= latIsLoad ? loadData_c : 32'h0;
      wbAluOut    <= latAlu;
    end else if (acceptPass_c | acceptTrap_c) begin
      wbValid     <= 1'b1;
      wbIsJal     <= exIsJal;
      wbM2reg     <= 1'b0;
      wbRegWrite  <= exRegWrite & ~acceptTrap_c;
      wbDestReg   <= exDestReg;
      wbPc4       <= exPc4;
      wbMemData   <= 32'h0;
      wbAluOut    <= exAluOut;
    end else if (bubble_c) begin
      wbValid     <= 1'b0;
      wbRegWrite  <= 1'b0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle trap pulse for a rejected misaligned access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalignTrap <= 1'b0;
    else     misalignTrap <= acceptTrap_c;
  end
`endif

endmodule
